// File: rtl/mic_pkg.sv
// Shared constants for the PDM microphone receiver.
//   CIC_ORDER   : number of integrator/comb stages
//   DECIM       : PDM-to-PCM decimation ratio
//   ACC_W       : CIC accumulator width (wrap-around arithmetic)
//   PCM_W       : output sample width
//   CIC_OFFSET  : mid-scale of the CIC output, subtracted to make samples signed
//   LEVEL_SHIFT : magnitude shift for the LED level bar
package mic_pkg;

  localparam int unsigned CIC_ORDER   = 3;
  localparam int unsigned DECIM       = 64;
  localparam int unsigned ACC_W       = 19;
  localparam int unsigned PCM_W       = 16;
  localparam int unsigned CIC_OFFSET  = 131072;
  localparam int unsigned LEVEL_SHIFT = 11;

  typedef logic [ACC_W-1:0] acc_t;

endpackage

// File: rtl/cic_decimator.sv
// CIC decimator (order CIC_ORDER, differential delay 1) with unsigned wrap-around accumulators.
// Ports:
//   CLK, RESETN : system clock, asynchronous active-low reset
//   bit_in      : PDM bit (1 -> +1, 0 -> 0)
//   bit_stb     : one-cycle strobe marking a valid PDM bit
//   clr         : synchronous clear of integrators, combs and decimation counter
//   dec_out     : decimated CIC output, valid while dec_stb is high
//   dec_stb     : one-cycle strobe, two cycles after the strobe that closes an epoch
module cic_decimator
  import mic_pkg::*;
#(
  parameter int unsigned Decim = mic_pkg::DECIM
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             bit_in,
  input  logic             bit_stb,
  input  logic             clr,
  output logic [ACC_W-1:0] dec_out,
  output logic             dec_stb
);

  localparam int unsigned CntW = (Decim > 1) ? $clog2(Decim) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Decim - 1);

  logic [CntW-1:0] cnt_q;
  acc_t            comb_in_q;
  logic            comb_go_q;
  acc_t            dec_out_q;
  logic            dec_stb_q;
  logic            epoch_end;

  assign epoch_end = bit_stb & (cnt_q == CntMax);

  // Each generate stage holds one integrator and one comb delay; stage g feeds stage g+1.
  for (genvar g = 0; g < CIC_ORDER; g++) begin : g_stage
    acc_t integ_q, integ_in, integ_d;
    acc_t comb_in, comb_z_q, comb_v;

    if (g == 0) begin : g_first
      assign integ_in = {{(ACC_W-1){1'b0}}, bit_in};
      assign comb_in  = comb_in_q;
    end else begin : g_rest
      assign integ_in = g_stage[g-1].integ_d;
      assign comb_in  = g_stage[g-1].comb_v;
    end

    assign integ_d = integ_q + integ_in;
    assign comb_v  = comb_in - comb_z_q;

    always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
        integ_q  <= '0;
        comb_z_q <= '0;
      end else if (clr) begin
        integ_q  <= '0;
        comb_z_q <= '0;
      end else begin
        if (bit_stb) integ_q <= integ_d;
        if (comb_go_q) comb_z_q <= comb_in;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      cnt_q     <= '0;
      comb_in_q <= '0;
      comb_go_q <= 1'b0;
      dec_out_q <= '0;
      dec_stb_q <= 1'b0;
    end else if (clr) begin
      cnt_q     <= '0;
      comb_in_q <= '0;
      comb_go_q <= 1'b0;
      dec_out_q <= '0;
      dec_stb_q <= 1'b0;
    end else begin
      if (bit_stb) cnt_q <= (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
      // Last integrator value including the closing bit is the comb input.
      if (epoch_end) comb_in_q <= g_stage[CIC_ORDER-1].integ_d;
      comb_go_q <= epoch_end;
      if (comb_go_q) dec_out_q <= g_stage[CIC_ORDER-1].comb_v;
      dec_stb_q <= comb_go_q;
    end
  end

  assign dec_out = dec_out_q;
  assign dec_stb = dec_stb_q;

endmodule

// File: rtl/mic_pdm_receiver.sv
// PDM microphone receiver: mic clock generation, data synchronizer, CIC decimation,
// conversion to signed PCM, valid/ready output with sticky overrun, and a level bar.
// Ports:
//   CLK, RESETN   : system clock, asynchronous active-low reset
//   mic_en        : capture enable
//   M_DATA        : PDM data from the microphone (asynchronous)
//   M_CLK         : microphone clock, M_LRSEL : channel select (always 0)
//   pcm_data      : signed PCM sample, pcm_valid/pcm_ready : output handshake
//   overrun       : sticky lost-sample flag, overrun_clr : one-cycle clear
//   level_monitor : min(15, |pcm_data| >> LEVEL_SHIFT)
module mic_pdm_receiver
  import mic_pkg::*;
#(
  parameter int unsigned CLK_HALF = 20,
  parameter int unsigned DECIM    = 64
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             mic_en,
  input  logic             M_DATA,
  output logic             M_CLK,
  output logic             M_LRSEL,
  output logic [PCM_W-1:0] pcm_data,
  output logic             pcm_valid,
  input  logic             pcm_ready,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic [3:0]       level_monitor
);

  localparam int unsigned DivW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_HALF - 1);
  localparam logic [1:0] SettleDone = 2'd3;
  localparam logic signed [ACC_W:0] Offset = (ACC_W+1)'(CIC_OFFSET);
  localparam logic signed [ACC_W:0] SatHi  = (ACC_W+1)'(CIC_OFFSET - 1);
  localparam logic [PCM_W-1:0] PcmMin = {1'b1, {(PCM_W-1){1'b0}}};
  localparam logic [PCM_W-1:0] PcmMax = {1'b0, {(PCM_W-1){1'b1}}};

  logic [DivW-1:0]  div_q, div_d;
  logic             mclk_q, mclk_d;
  logic [1:0]       sync_q;
  logic [1:0]       settle_q, settle_d;
  logic [PCM_W-1:0] pcm_q, pcm_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic [3:0]       level_q, level_d;

  logic             sample_stb;
  logic             cic_clr;
  acc_t             dec_out;
  logic             dec_stb;
  logic             load;

  logic signed [ACC_W:0] conv_s;
  logic [PCM_W+1:0]      conv_sat;
  logic [PCM_W-1:0]      conv_pcm;
  logic [PCM_W-1:0]      mag;
  logic [PCM_W-1:0]      lvl_full;
  logic [3:0]            lvl_new;
  logic                  unused_conv;

  // Mic clock divider; the sample cycle is the one that drives M_CLK from 1 to 0.
  always_comb begin
    div_d  = div_q;
    mclk_d = mclk_q;
    if (!mic_en) begin
      div_d  = '0;
      mclk_d = 1'b0;
    end else if (div_q == DivMax) begin
      div_d  = '0;
      mclk_d = ~mclk_q;
    end else begin
      div_d = div_q + DivW'(1);
    end
  end

  assign sample_stb = mic_en & mclk_q & (div_q == DivMax);
  assign cic_clr    = ~mic_en;

  cic_decimator #(
    .Decim (DECIM)
  ) u_cic (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .bit_in  (sync_q[1]),
    .bit_stb (sample_stb),
    .clr     (cic_clr),
    .dec_out (dec_out),
    .dec_stb (dec_stb)
  );

  // Conversion: only the upper bound can saturate, since dec_out >= 0 gives s >= -CIC_OFFSET.
  always_comb begin
    conv_s   = $signed({1'b0, dec_out}) - Offset;
    conv_sat = (conv_s > SatHi) ? SatHi[PCM_W+1:0] : conv_s[PCM_W+1:0];
    conv_pcm = conv_sat[PCM_W+1:2];
    if (conv_pcm[PCM_W-1]) begin
      mag = (conv_pcm == PcmMin) ? PcmMax : -conv_pcm;
    end else begin
      mag = conv_pcm;
    end
    lvl_full = mag >> LEVEL_SHIFT;
    lvl_new  = (lvl_full > PCM_W'(15)) ? 4'hf : lvl_full[3:0];
  end

  assign unused_conv = ^{conv_s[ACC_W:PCM_W+2], conv_sat[1:0]};

  // The first three decimation outputs after enable only flush the CIC and are dropped.
  always_comb begin
    settle_d = settle_q;
    if (!mic_en) begin
      settle_d = '0;
    end else if (dec_stb && (settle_q != SettleDone)) begin
      settle_d = settle_q + 2'd1;
    end
  end

  assign load = mic_en & dec_stb & (settle_q == SettleDone);

  always_comb begin
    pcm_d   = load ? conv_pcm : pcm_q;
    level_d = load ? lvl_new : level_q;
    valid_d = load | (valid_q & ~pcm_ready);
    // A set in the same cycle as a clear wins.
    ovr_d   = (load & valid_q & ~pcm_ready) | (ovr_q & ~overrun_clr);
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      div_q    <= '0;
      mclk_q   <= 1'b0;
      sync_q   <= '0;
      settle_q <= '0;
      pcm_q    <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
      level_q  <= '0;
    end else begin
      div_q    <= div_d;
      mclk_q   <= mclk_d;
      sync_q   <= {sync_q[0], M_DATA};
      settle_q <= settle_d;
      pcm_q    <= pcm_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
      level_q  <= level_d;
    end
  end

  assign M_CLK         = mclk_q;
  assign M_LRSEL       = 1'b0;
  assign pcm_data      = pcm_q;
  assign pcm_valid     = valid_q;
  assign overrun       = ovr_q;
  assign level_monitor = level_q;

endmodule

// File: tb/tb_mic_pdm_receiver.sv
// Self-checking bench for mic_pdm_receiver: table of PDM density patterns with known
// steady-state PCM results, plus sequences for overrun, enable drop and mid-run reset.
module tb_mic_pdm_receiver;

  localparam int Epoch = 64 * 40;     // CLK cycles per decimated sample
  localparam int Lat   = 4 * Epoch + 2; // enable to first pcm_valid

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        mic_en = 1'b0;
  logic        M_DATA = 1'b0;
  logic        pcm_ready = 1'b0;
  logic        overrun_clr = 1'b0;
  logic        M_CLK;
  logic        M_LRSEL;
  logic [15:0] pcm_data;
  logic        pcm_valid;
  logic        overrun;
  logic [3:0]  level_monitor;

  always #5 CLK = ~CLK;

  mic_pdm_receiver #(
    .CLK_HALF (20),
    .DECIM    (64)
  ) dut (
    .CLK           (CLK),
    .RESETN        (RESETN),
    .mic_en        (mic_en),
    .M_DATA        (M_DATA),
    .M_CLK         (M_CLK),
    .M_LRSEL       (M_LRSEL),
    .pcm_data      (pcm_data),
    .pcm_valid     (pcm_valid),
    .pcm_ready     (pcm_ready),
    .overrun       (overrun),
    .overrun_clr   (overrun_clr),
    .level_monitor (level_monitor)
  );

  typedef struct {
    int    per;
    int    ones;
    int    pcm;
    int    lvl;
    string name;
  } vec_t;

  typedef struct {
    int pcm;
    int lvl;
  } exp_t;

  vec_t vt[5];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   per = 1;
  int   ones = 0;
  int   ph = 0;

  // Microphone model: new bit shortly after each M_CLK rise, periodic pattern of density ones/per.
  initial begin
    forever begin
      @(posedge M_CLK);
      #1;
      M_DATA = ((ph % per) < ones);
      ph++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: sample %0d with no expected entry", tag, $signed(pcm_data));
      return;
    end
    e = sb.pop_front();
    chk({tag, "_pcm"}, int'($signed(pcm_data)), e.pcm);
    chk({tag, "_lvl"}, int'(level_monitor), e.lvl);
  endtask

  task automatic wait_valid(input int budget, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < budget && !ok) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (pcm_valid) ok = 1'b1;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mclk"}, int'(M_CLK), 0);
    chk({tag, "_lrsel"}, int'(M_LRSEL), 0);
    chk({tag, "_pcm"}, int'(pcm_data), 0);
    chk({tag, "_valid"}, int'(pcm_valid), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
    chk({tag, "_level"}, int'(level_monitor), 0);
  endtask

  initial begin
    int   cyc;
    bit   ok;
    bit   seen;
    int   hi;
    int   lo;
    exp_t last;

    vt[0] = '{1, 1, 32767, 15, "all_ones"};
    vt[1] = '{2, 1, 0, 0, "half"};
    vt[2] = '{1, 0, -32768, 15, "all_zeros"};
    vt[3] = '{4, 3, 16384, 8, "three_quarter"};
    vt[4] = '{8, 1, -24576, 12, "one_eighth"};

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_outputs("reset");
    #2 RESETN = 1'b1;
    @(posedge CLK);
    #1;

    // M_CLK timing: first rise after 20 cycles, then 20 high / 20 low
    mic_en = 1'b1;
    cyc = 0;
    while (!M_CLK && cyc < 100) begin
      @(posedge CLK);
      #1;
      cyc++;
    end
    chk("mclk_first_rise", cyc, 20);
    hi = 0;
    while (M_CLK && hi < 100) begin
      @(posedge CLK);
      #1;
      hi++;
    end
    lo = 0;
    while (!M_CLK && lo < 100) begin
      @(posedge CLK);
      #1;
      lo++;
    end
    chk("mclk_high", hi, 20);
    chk("mclk_low", lo, 20);

    // Density table: each vector restarts capture, so the first output is settled data
    pcm_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mic_en = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      per  = vt[i].per;
      ones = vt[i].ones;
      ph   = 0;
      sb.push_back('{vt[i].pcm, vt[i].lvl});
      mic_en = 1'b1;
      wait_valid(Lat + 100, cyc, ok);
      chk({vt[i].name, "_seen"}, int'(ok), 1);
      chk({vt[i].name, "_latency"}, cyc, Lat);
      if (ok) sb_check(vt[i].name);
      else sb.delete();
      if (i == 0) begin
        @(posedge CLK);
        #1;
        chk("ones_valid_fall", int'(pcm_valid), 0);
        sb.push_back('{vt[0].pcm, vt[0].lvl});
        wait_valid(Epoch + 100, cyc, ok);
        chk("ones_period", cyc + 1, Epoch);
        if (ok) sb_check("ones_second");
        else sb.delete();
      end
    end
    last = '{vt[4].pcm, vt[4].lvl};

    // Overrun: hold off the consumer across two loads
    @(posedge CLK);
    #1;
    pcm_ready = 1'b0;
    sb.push_back(last);
    wait_valid(Epoch + 100, cyc, ok);
    chk("ovr_first_seen", int'(ok), 1);
    chk("ovr_before_second", int'(overrun), 0);
    sb_check("ovr_first");
    cyc = 0;
    while (!overrun && cyc < Epoch + 100) begin
      @(posedge CLK);
      #1;
      cyc++;
    end
    chk("ovr_set_cycle", cyc, Epoch);
    chk("ovr_valid_held", int'(pcm_valid), 1);
    sb.push_back(last);
    sb_check("ovr_latest");
    overrun_clr = 1'b1;
    @(posedge CLK);
    #1;
    overrun_clr = 1'b0;
    chk("ovr_clr", int'(overrun), 0);
    // Clear held through the next load: set must win on the load cycle
    overrun_clr = 1'b1;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < Epoch + 100) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (overrun) seen = 1'b1;
    end
    overrun_clr = 1'b0;
    chk("ovr_set_wins", int'(seen), 1);

    // Enable drop with a pending sample
    mic_en = 1'b0;
    @(posedge CLK);
    #1;
    chk("drop_mclk", int'(M_CLK), 0);
    chk("drop_valid_held", int'(pcm_valid), 1);
    chk("drop_overrun_held", int'(overrun), 1);
    sb.push_back(last);
    sb_check("drop_hold");
    pcm_ready = 1'b1;
    @(posedge CLK);
    #1;
    chk("drop_handshake", int'(pcm_valid), 0);
    seen = 1'b0;
    repeat (Epoch) begin
      @(posedge CLK);
      #1;
      if (pcm_valid) seen = 1'b1;
    end
    chk("drop_no_valid", int'(seen), 0);
    sb.push_back(last);
    mic_en = 1'b1;
    wait_valid(Lat + 100, cyc, ok);
    chk("reenable_latency", cyc, Lat);
    if (ok) sb_check("reenable");
    else sb.delete();

    // Reset around decimation count 30
    @(posedge CLK);
    repeat (30 * 40) @(posedge CLK);
    #3;
    RESETN = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    #1;
    RESETN = 1'b1;
    sb.push_back(last);
    wait_valid(Lat + 100, cyc, ok);
    chk("midrst_latency", cyc, Lat);
    if (ok) sb_check("midrst");
    else sb.delete();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mic_pdm_receiver.md
MIC_PDM_RECEIVER -- requirements
Module: mic_pdm_receiver

Interface
REQ-001 The block SHALL have parameter CLK_HALF, default 20: CLK cycles per mic-clock half period, giving a 2.5 MHz mic clock from 100 MHz.
REQ-002 The block SHALL have parameter DECIM, default 64, fixed: the PDM-to-PCM decimation ratio, giving 39062.5 Hz output.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single system clock, all logic on its rising edge.
REQ-004 The block SHALL have port RESETN, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port mic_en, input, 1 bit: capture enable.
REQ-006 The block SHALL have port M_DATA, input, 1 bit: PDM data from the microphone, asynchronous to CLK.
REQ-007 The block SHALL have port M_CLK, output, 1 bit: the microphone clock.
REQ-008 The block SHALL have port M_LRSEL, output, 1 bit: microphone channel select, constant 0.
REQ-009 The block SHALL have port pcm_data, output, 16 bits: signed PCM sample.
REQ-010 The block SHALL have port pcm_valid, output, 1 bit: sample available.
REQ-011 The block SHALL have port pcm_ready, input, 1 bit: consumer accepts the sample.
REQ-012 The block SHALL have port overrun, output, 1 bit: sticky flag, set when an unaccepted sample is lost.
REQ-013 The block SHALL have port overrun_clr, input, 1 bit: single-cycle clear for overrun.
REQ-014 The block SHALL have port level_monitor, output, 4 bits: magnitude bar for LEDs.

Function
REQ-015 While mic_en=1, M_CLK SHALL toggle every CLK_HALF CLK cycles; while mic_en=0, it SHALL be held at 0 and the divider counter held at 0.
REQ-016 M_DATA SHALL pass through a two-flop synchronizer, then be sampled in the CLK cycle in which M_CLK is driven from 1 to 0 (the sample cycle).
REQ-017 Decimation SHALL be a 3rd-order CIC (N=3, R=64, M=1) with 19-bit unsigned wrap-around arithmetic, PDM 1 mapping to 1 and PDM 0 mapping to 0.
REQ-018 The integrators SHALL update on every sample cycle.
REQ-019 A decimation counter SHALL wrap from 63 to 0, and the comb input SHALL be taken on the sample cycle where the counter is 63.
REQ-020 The comb stage SHALL be registered on sample cycle +1; the conversion SHALL be computed and registered into pcm_data on sample cycle +2.
REQ-021 Conversion: s = comb_out - 131072, saturated to the range [-131072, +131071], then pcm_data = s[17:2].
REQ-022 Conversion limits: all-ones input gives 32767, all-zeros input gives -32768, 50% density gives 0.
REQ-023 The first 3 decimation outputs after reset or after a mic_en rising edge SHALL be discarded (settling), with pcm_valid not asserted.
REQ-024 Handshake: pcm_valid SHALL rise with the pcm_data update.
REQ-025 Handshake: pcm_valid SHALL stay high and pcm_data SHALL stay stable until a cycle with pcm_valid=1 and pcm_ready=1; pcm_valid SHALL fall the following cycle unless a new sample loads in that same cycle.
REQ-026 If a new sample loads while pcm_valid=1 and pcm_ready=0, the new sample SHALL overwrite pcm_data, pcm_valid SHALL remain 1, and overrun SHALL be set.
REQ-027 If a set and overrun_clr occur in the same cycle, set SHALL win.
REQ-028 If a load and a handshake coincide, the new sample SHALL load, pcm_valid SHALL remain 1, and overrun SHALL not be set.
REQ-029 level_monitor SHALL be min(15, |pcm_data| >> 11), updated on each pcm_data load, with |-32768| treated as 32767.
REQ-030 When mic_en falls, the integrators, combs, decimation counter and settling counter SHALL clear on the next CLK.
REQ-031 When mic_en falls, pcm_data, pcm_valid and overrun SHALL retain their values, and a pending sample SHALL still be accepted via handshake.

Reset
REQ-032 On RESETN=0, asynchronously: M_CLK=0, pcm_data=0, pcm_valid=0, overrun=0, level_monitor=0.
REQ-033 On RESETN=0, asynchronously: synchronizer flops, divider, integrators, combs, decimation counter and settling counter SHALL be 0.
REQ-034 M_LRSEL SHALL be 0 at all times, including during reset.
REQ-035 A reset assertion mid-decimation SHALL discard the partial sample, with no pcm_valid pulse.

Structure
REQ-036 Shared package mic_pkg SHALL hold the constants CIC_ORDER=3, DECIM=64, ACC_W=19, PCM_W=16, CIC_OFFSET=131072 and LEVEL_SHIFT=11.
REQ-037 One sub-module, cic_decimator, SHALL contain the integrators, decimation counter and combs.
REQ-038 cic_decimator SHALL have inputs bit_in, bit_stb and clr, and outputs dec_out[18:0] and dec_stb.
REQ-039 The clock divider, synchronizer, conversion, handshake and level logic SHALL live in mic_pdm_receiver.

Verification
REQ-040 mic_en=1, M_DATA constant 1, pcm_ready=1 -> first pcm_valid after the 4th decimation epoch, pcm_data=32767, level_monitor=15, every 2560 CLK cycles thereafter.
REQ-041 M_DATA alternating 1,0 per sample cycle -> pcm_data=0 and level_monitor=0 after settling; constant 0 -> pcm_data=-32768 and level_monitor=15.
REQ-042 Steady samples, pcm_ready=0 for 2 output periods -> overrun=1 after the second load, pcm_data equals the latest sample; overrun_clr pulse -> overrun=0.
REQ-043 RESETN pulsed low at decimation count 30 -> all outputs 0 immediately, M_CLK=0, and the next pcm_valid occurs 4 full epochs after release.
REQ-044 mic_en dropped with pcm_valid=1 -> M_CLK=0 within 1 cycle, pcm_data held, handshake still completes, and no new pcm_valid until 4 epochs after re-enable.
REQ-045 M_CLK period check -> exactly 40 CLK cycles with a 50% duty cycle, and the sample cycle coincides with the M_CLK falling edge.
